// File: rtl/up_counter.sv
// Parameterised up-counter with enable, synchronous clear/load, a programmable
// terminal value, and a choice of wrapping or saturating at that value.
module up_counter #(
  parameter int WIDTH    = 4,
  parameter int MAX_VAL  = (2 ** WIDTH) - 1,
  parameter bit SATURATE = 1'b0,
  parameter int STEP     = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en       = 1'b1,
  input  logic             clear    = 1'b0,
  input  logic             load     = 1'b0,
  input  logic [WIDTH-1:0] load_val = '0,
  output logic [WIDTH-1:0] counter,
  output logic             tc,
  output logic             wrap,
  output logic             ovf
);

  localparam logic [WIDTH:0] MAX_X  = (WIDTH+1)'(MAX_VAL);
  localparam logic [WIDTH:0] STEP_X = (WIDTH+1)'(STEP);
  localparam logic [WIDTH:0] MOD_X  = MAX_X + (WIDTH+1)'(1);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   wrapped;
  logic [WIDTH:0]   load_x;
  logic [WIDTH-1:0] counter_nxt;
  logic             wrap_nxt;
  logic             ovf_nxt;

  // One extra bit on the sum so an overshoot past MAX_VAL is never lost.
  assign sum     = {1'b0, counter} + STEP_X;
  assign wrapped = sum - MOD_X;
  assign load_x  = {1'b0, load_val};

  always_comb begin
    counter_nxt = counter;
    wrap_nxt    = 1'b0;
    ovf_nxt     = ovf;
    if (clear) begin
      counter_nxt = '0;
      ovf_nxt     = 1'b0;
    end else if (load) begin
      counter_nxt = (load_x > MAX_X) ? MAX_X[WIDTH-1:0] : load_val;
    end else if (en) begin
      if (sum <= MAX_X) begin
        counter_nxt = sum[WIDTH-1:0];
      end else begin
        counter_nxt = SATURATE ? MAX_X[WIDTH-1:0] : wrapped[WIDTH-1:0];
        wrap_nxt    = 1'b1;
        ovf_nxt     = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      counter <= '0;
      wrap    <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      counter <= counter_nxt;
      wrap    <= wrap_nxt;
      ovf     <= ovf_nxt;
    end
  end

  assign tc = (counter == MAX_X[WIDTH-1:0]);

endmodule

// File: tb/tb_up_counter.sv
// Directed bench: a default wrapping counter (a) and a MAX_VAL=9 saturating one (b)
// share clock and reset; expected values are hand-computed per step.
module tb_up_counter;

  logic       clk = 1'b0;
  logic       reset;
  logic       en_a, clear_a, load_a;
  logic [3:0] load_val_a;
  logic [3:0] counter_a;
  logic       tc_a, wrap_a, ovf_a;
  logic       en_b, clear_b, load_b;
  logic [3:0] load_val_b;
  logic [3:0] counter_b;
  logic       tc_b, wrap_b, ovf_b;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  up_counter #(.WIDTH(4)) dut_a (
    .clk(clk), .reset(reset), .en(en_a), .clear(clear_a), .load(load_a),
    .load_val(load_val_a), .counter(counter_a), .tc(tc_a), .wrap(wrap_a), .ovf(ovf_a)
  );

  up_counter #(.WIDTH(4), .MAX_VAL(9), .SATURATE(1'b1)) dut_b (
    .clk(clk), .reset(reset), .en(en_b), .clear(clear_b), .load(load_b),
    .load_val(load_val_b), .counter(counter_b), .tc(tc_b), .wrap(wrap_b), .ovf(ovf_b)
  );

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic edge_a();
    @(posedge clk);
    #1;
  endtask

  task automatic check_a(input string tag, input int c, input int t, input int w, input int o);
    check({tag, ".counter_a"}, int'(counter_a), c);
    check({tag, ".tc_a"}, int'(tc_a), t);
    check({tag, ".wrap_a"}, int'(wrap_a), w);
    check({tag, ".ovf_a"}, int'(ovf_a), o);
  endtask

  task automatic check_b(input string tag, input int c, input int t, input int w, input int o);
    check({tag, ".counter_b"}, int'(counter_b), c);
    check({tag, ".tc_b"}, int'(tc_b), t);
    check({tag, ".wrap_b"}, int'(wrap_b), w);
    check({tag, ".ovf_b"}, int'(ovf_b), o);
  endtask

  initial begin
    reset = 1'b1;
    en_a = 1'b1; clear_a = 1'b0; load_a = 1'b0; load_val_a = 4'd0;
    en_b = 1'b1; clear_b = 1'b0; load_b = 1'b0; load_val_b = 4'd0;

    // Reset asserted at t=1, released at t=20 between edges.
    #1 reset = 1'b0;
    #2;
    check_a("rst_async", 0, 0, 0, 0);
    check_b("rst_async", 0, 0, 0, 0);
    edge_a();
    edge_a();
    check_a("rst_held_edge", 0, 0, 0, 0);
    #4 reset = 1'b1;

    // Free-run: a wraps after 15, b saturates at 9.
    for (int i = 1; i <= 17; i++) begin
      edge_a();
      if (i <= 15)      check_a($sformatf("run%0d", i), i, (i == 15) ? 1 : 0, 0, 0);
      else if (i == 16) check_a("wrap_hit", 0, 0, 1, 1);
      else              check_a("after_wrap", 1, 0, 0, 1);
      if (i <= 9)       check_b($sformatf("sat_run%0d", i), i, (i == 9) ? 1 : 0, 0, 0);
      else if (i == 10) check_b("sat_hit", 9, 1, 1, 1);
      else              check_b("sat_idle", 9, 1, 0, 1);
      if (i == 10) en_b = 1'b0;
    end

    // Count a up to 5, then hold for 3 cycles.
    repeat (4) edge_a();
    check_a("reach5", 5, 0, 0, 1);
    en_a = 1'b0;
    for (int i = 0; i < 3; i++) begin
      edge_a();
      check_a($sformatf("hold%0d", i), 5, 0, 0, 1);
    end
    en_a = 1'b1;
    edge_a();
    check_a("resume6", 6, 0, 0, 1);

    // Load beats en; b clamps an out-of-range load to MAX_VAL.
    load_a = 1'b1; load_val_a = 4'd12;
    load_b = 1'b1; load_val_b = 4'd14;
    edge_a();
    check_a("load12", 12, 0, 0, 1);
    check_b("load_clamp", 9, 1, 0, 1);
    load_b = 1'b0;
    clear_a = 1'b1; load_val_a = 4'd3;
    edge_a();
    check_a("clear_wins", 0, 0, 0, 0);
    clear_a = 1'b0; load_a = 1'b0;

    // Count a to 8, then reset asynchronously mid-cycle.
    repeat (8) edge_a();
    check_a("reach8", 8, 0, 0, 0);
    #3 reset = 1'b0;
    #1;
    check_a("rst_mid", 0, 0, 0, 0);
    check_b("rst_mid", 0, 0, 0, 0);
    #3 reset = 1'b1;
    edge_a();
    check_a("restart1", 1, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
